// File: rtl/gaussian_window_ctrl.sv
// gaussian_window_ctrl
// Turns a raster stream of RGB565 pixels into 3x3 neighbourhoods for a
// Gaussian filter datapath. Two line buffers supply the two lines above the
// incoming pixel; a two-column shift register plus the incoming column forms
// the 3x3 window. Windows are emitted only where the full neighbourhood lies
// inside the image (no border padding), so a frame yields
// (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
module gaussian_window_ctrl #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic         d_clk,
    input  logic         rst_n,
    input  logic         vsync,
    input  logic         pix_valid,
    input  logic [15:0]  pix_data,
    output logic [143:0] window_data,
    output logic         window_valid,
    output logic         frame_done,
    output logic         busy
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    // Position of the next pixel to be accepted
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Frame control
    logic r_done;
    logic r_busy;
    logic r_frame_done;
    logic r_wvalid;

    // Line buffers: r_lb1 holds line row-1, r_lb2 holds line row-2
    logic [15:0] r_lb1 [IMG_WIDTH];
    logic [15:0] r_lb2 [IMG_WIDTH];

    // Window columns {top, middle, bottom}: c1 = column col-1, c2 = column col-2
    logic [47:0] r_win_c1;
    logic [47:0] r_win_c2;

    // Registered window presented to the datapath
    logic [143:0] r_window;

    logic         w_accept;
    logic         w_last_col;
    logic         w_last_row;
    logic         w_win_ok;
    logic [15:0]  w_lb1_rd;
    logic [15:0]  w_lb2_rd;
    logic [47:0]  w_col;
    logic [143:0] w_window;

    // Once the frame is complete, pixels are ignored until vsync rearms it
    assign w_accept   = pix_valid && !vsync && !r_done;
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);
    // A full neighbourhood exists only from the third row and third column on,
    // which also guarantees every line-buffer word used was written this frame
    assign w_win_ok   = (r_row >= RW'(2)) && (r_col >= CW'(2));

    assign w_lb1_rd = r_lb1[r_col];
    assign w_lb2_rd = r_lb2[r_col];
    assign w_col    = {w_lb2_rd, w_lb1_rd, pix_data};

    // Row-major element order: element 0 (top-left) in the top 16 bits
    assign w_window = {r_win_c2[47:32], r_win_c1[47:32], w_col[47:32],
                       r_win_c2[31:16], r_win_c1[31:16], w_col[31:16],
                       r_win_c2[15:0],  r_win_c1[15:0],  w_col[15:0]};

    // Line buffers shift one line down at the current column on each accepted pixel
    always_ff @(posedge d_clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= pix_data;
        end
    end

    // Counters, column window, output window and frame status
    always_ff @(posedge d_clk) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_wvalid     <= 1'b0;
            r_win_c1     <= '0;
            r_win_c2     <= '0;
            r_window     <= '0;
        end else if (vsync) begin
            // Between frames: rearm and abort anything in progress; the
            // output window keeps its last value
            r_col        <= '0;
            r_row        <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_wvalid     <= 1'b0;
            r_win_c1     <= '0;
            r_win_c2     <= '0;
        end else begin
            r_wvalid     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                if (w_last_col) begin
                    // Start each line with an empty window so none straddles lines
                    r_col    <= '0;
                    r_win_c1 <= '0;
                    r_win_c2 <= '0;
                    if (w_last_row) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col    <= r_col + CW'(1);
                    r_win_c2 <= r_win_c1;
                    r_win_c1 <= w_col;
                end

                if (w_win_ok) begin
                    r_wvalid <= 1'b1;
                    r_window <= w_window;
                end

                if (w_last_col && w_last_row) begin
                    r_done       <= 1'b1;
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                end else begin
                    r_busy <= 1'b1;
                end
            end
        end
    end

    assign window_data  = r_window;
    // A window registered just before vsync rises is suppressed while vsync is high
    assign window_valid = r_wvalid && !vsync;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;

endmodule
